// File: rtl/dma_read_2d_pkg.sv
// Shared types and helpers for the 2-D strided read DMA.
package dma_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/dma_read_2d_stream_fifo.sv
// Synchronous FIFO with flush; head entry is presented combinationally.
module stream_fifo import dma_pkg::*; #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8,
    localparam int CW = clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic             push, pop;

    // Upstream credit accounting guarantees a push never hits a full FIFO.
    assign push    = s_valid;
    assign pop     = m_valid && m_ready;
    assign m_valid = (count != '0);
    assign m_data  = mem[rd_ptr];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop)  rd_ptr <= nxt(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= s_data;
    end
endmodule

// File: rtl/dma_read_2d.sv
// 2-D strided read DMA: memory request/response port in, AXI-Stream out,
// with FIFO-credit flow control so in-flight responses always have a slot.
module dma_read_2d import dma_pkg::*; #(
    parameter int DATA_W          = 8,
    parameter int ADDR_W          = 32,
    parameter int LEN_W           = 16,
    parameter int MAX_OUTSTANDING = 8,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  row_beats,
    input  logic [LEN_W-1:0]  rows,
    input  logic [ADDR_W-1:0] stride,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    input  logic              mem_resp_err,
    output logic              m_tvalid,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast,
    input  logic              m_tready
);
    localparam int BPB = DATA_W / 8;
    localparam int OW  = clog2(MAX_OUTSTANDING + 1);
    localparam int FCW = clog2(FIFO_DEPTH + 1);

    state_t            state;
    logic [ADDR_W-1:0] row_addr, beat_addr, stride_r;
    logic [LEN_W-1:0]  row_beats_r, rows_r, req_beat, req_row, rsp_beat;
    logic              reqs_left;
    logic [OW-1:0]     outstanding;
    logic [FCW-1:0]    fifo_count;
    logic              req_fire, resp_take, fifo_push, flush;

    // Credit check: every in-flight request already owns a FIFO slot.
    assign mem_req_valid = (state == RUN) && reqs_left && !abort
                        && (outstanding < OW'(MAX_OUTSTANDING))
                        && (int'(outstanding) + int'(fifo_count) < FIFO_DEPTH);
    assign mem_req_addr  = beat_addr;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign resp_take     = mem_resp_valid && (state != IDLE);
    assign fifo_push     = mem_resp_valid && (state == RUN) && !abort;
    assign flush         = (state == RUN) && abort;

    stream_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .s_valid (fifo_push),
        .s_data  ({rsp_beat == row_beats_r - 1'b1, mem_resp_rdata}),
        .m_valid (m_tvalid),
        .m_data  ({m_tlast, m_tdata}),
        .m_ready (m_tready),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            err         <= 1'b0;
            row_addr    <= '0;
            beat_addr   <= '0;
            stride_r    <= '0;
            row_beats_r <= '0;
            rows_r      <= '0;
            req_beat    <= '0;
            req_row     <= '0;
            rsp_beat    <= '0;
            reqs_left   <= 1'b0;
            outstanding <= '0;
        end else begin
            done <= 1'b0;

            if (req_fire && !resp_take)      outstanding <= outstanding + 1'b1;
            else if (!req_fire && resp_take) outstanding <= outstanding - 1'b1;

            if (resp_take) begin
                if (mem_resp_err) err <= 1'b1;
                rsp_beat <= (rsp_beat == row_beats_r - 1'b1) ? '0 : rsp_beat + 1'b1;
            end

            if (req_fire) begin
                if (req_beat == row_beats_r - 1'b1) begin
                    req_beat  <= '0;
                    row_addr  <= row_addr + stride_r;
                    beat_addr <= row_addr + stride_r;
                    if (req_row == rows_r - 1'b1) reqs_left <= 1'b0;
                    else                          req_row   <= req_row + 1'b1;
                end else begin
                    req_beat  <= req_beat + 1'b1;
                    beat_addr <= beat_addr + ADDR_W'(BPB);
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        row_addr    <= base_addr;
                        beat_addr   <= base_addr;
                        stride_r    <= stride;
                        row_beats_r <= row_beats;
                        rows_r      <= rows;
                        req_beat    <= '0;
                        req_row     <= '0;
                        rsp_beat    <= '0;
                        aborted     <= 1'b0;
                        err         <= 1'b0;
                        if (rows == '0 || row_beats == '0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            reqs_left <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= DRAIN;
                        reqs_left <= 1'b0;
                    end else if (!reqs_left && outstanding == '0 && fifo_count == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_read_2d.sv
// Directed bench for dma_read_2d: memory model with configurable latency and
// ready pattern, address/beat scoreboards, flow-control invariants.
module tb_dma_read_2d;
    localparam int DW = 32, AW = 32, LW = 16, MAXO = 8, FD = 8;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          start = 1'b0, abort = 1'b0;
    logic [AW-1:0] base_addr = '0, stride = '0;
    logic [LW-1:0] row_beats = '0, rows = '0;
    logic          busy, done, aborted, err;
    logic          mem_req_valid, mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_resp_valid, mem_resp_err;
    logic [DW-1:0] mem_resp_rdata;
    logic          m_tvalid, m_tlast, m_tready;
    logic [DW-1:0] m_tdata;

    always #5 clk = ~clk;

    dma_read_2d #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW),
                  .MAX_OUTSTANDING(MAXO), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .row_beats(row_beats), .rows(rows), .stride(stride),
        .busy(busy), .done(done), .aborted(aborted), .err(err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready)
    );

    typedef struct {int due; logic [DW-1:0] data; logic err;} resp_t;

    int errors = 0, checks = 0, cyc = 0;
    logic [AW-1:0] exp_addr[$];
    logic [DW:0]   exp_beats[$];
    resp_t         pend[$];
    int  lat = 1, err_idx = -1;
    bit  toggle_ready = 0, hold_tready = 0;
    int  xfer_acc = 0, accepts = 0, pops = 0, bench_out = 0;
    int  done_cnt = 0, done_cyc = 0, start_cyc = 0;
    logic done_err = 0, done_abt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model and stream monitor: inputs change on negedge, handshakes
    // are observed 1 time unit later, before the next active edge.
    initial begin
        logic          stall_req = 0, stall_s = 0;
        logic [AW-1:0] prev_addr = '0;
        logic [DW:0]   prev_s = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0; mem_resp_err = 0; m_tready = 0;
        forever begin
            @(negedge clk);
            mem_req_ready = toggle_ready ? cyc[0] : 1'b1;
            m_tready = !hold_tready;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = pend[0].data;
                mem_resp_err   = pend[0].err;
                void'(pend.pop_front());
                bench_out--;
            end else begin
                mem_resp_valid = 1'b0;
                mem_resp_err   = 1'b0;
            end
            #1;
            if (stall_req && !abort) check("req_addr_stable", {mem_req_valid, mem_req_addr}, {1'b1, prev_addr});
            if (mem_req_valid && mem_req_ready) begin
                if (exp_addr.size() == 0) check("req_unexpected", 1, 0);
                else check("req_addr", mem_req_addr, exp_addr.pop_front());
                pend.push_back('{cyc + lat, data_of(mem_req_addr), xfer_acc == err_idx});
                xfer_acc++; accepts++; bench_out++;
            end
            stall_req = mem_req_valid && !mem_req_ready;
            prev_addr = mem_req_addr;
            if (stall_s) check("stream_stable", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_s});
            if (m_tvalid && m_tready) begin
                if (exp_beats.size() == 0) check("beat_unexpected", 1, 0);
                else check("beat", {m_tlast, m_tdata}, exp_beats.pop_front());
                pops++;
            end
            stall_s = m_tvalid && !m_tready;
            prev_s  = {m_tlast, m_tdata};
            check("outstanding_max", bench_out <= MAXO, 1);
            check("credit", (accepts - pops) <= FD, 1);
            if (done) begin
                done_cnt++; done_cyc = cyc; done_err = err; done_abt = aborted;
            end
        end
    end

    task automatic run_start(input logic [AW-1:0] b, input int rb, input int nr, input logic [AW-1:0] st);
        exp_addr.delete(); exp_beats.delete();
        for (int r = 0; r < nr; r++)
            for (int k = 0; k < rb; k++) begin
                logic [AW-1:0] a;
                a = b + AW'(r) * st + AW'(k * 4);
                exp_addr.push_back(a);
                exp_beats.push_back({k == rb - 1, data_of(a)});
            end
        xfer_acc = 0; accepts = 0; pops = 0;
        @(negedge clk);
        base_addr = b; row_beats = LW'(rb); rows = LW'(nr); stride = st;
        start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0);
        int k = 0;
        while (done_cnt == n0 && k < 2000) begin @(negedge clk); k++; end
        check("done_seen", done_cnt > n0, 1);
        repeat (3) @(negedge clk);
        check("single_done", done_cnt, n0 + 1);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        int n0, acc_ab, k;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_status", {aborted, err}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic 2x3 transfer, 1-cycle latency
        n0 = done_cnt;
        run_start(32'h100, 3, 2, 32'h40);
        wait_done(n0);
        check("t1_accepts", accepts, 6);
        check("t1_beats", pops, 6);
        check("t1_leftover", exp_beats.size() + exp_addr.size(), 0);
        check("t1_status", {done_abt, done_err}, 0);

        // Stream backpressure for 20 cycles
        hold_tready = 1;
        n0 = done_cnt;
        run_start(32'h200, 4, 4, 32'h80);
        repeat (20) @(negedge clk);
        check("t2_credit_fill", accepts, FD);
        check("t2_no_beats", pops, 0);
        hold_tready = 0;
        wait_done(n0);
        check("t2_beats", pops, 16);
        check("t2_leftover", exp_beats.size(), 0);

        // Toggling request ready, 5-cycle latency
        toggle_ready = 1; lat = 5;
        n0 = done_cnt;
        run_start(32'h1000, 5, 3, 32'h100);
        wait_done(n0);
        check("t3_beats", pops, 15);
        check("t3_leftover", exp_beats.size(), 0);
        toggle_ready = 0; lat = 1;

        // Degenerate sizes
        n0 = done_cnt;
        run_start(32'h300, 3, 0, 32'h40);
        wait_done(n0);
        check("t4_done_latency", done_cyc, start_cyc + 1);
        check("t4_no_traffic", {accepts, pops}, 0);
        n0 = done_cnt;
        run_start(32'h300, 0, 2, 32'h40);
        wait_done(n0);
        check("t4b_done_latency", done_cyc, start_cyc + 1);
        check("t4b_no_traffic", {accepts, pops}, 0);

        // Abort after two beats delivered
        lat = 3;
        n0 = done_cnt;
        run_start(32'h2000, 4, 4, 32'h40);
        k = 0;
        while (pops < 2 && k < 500) begin @(negedge clk); k++; end
        check("t5_reached_two", pops >= 2, 1);
        abort = 1'b1;
        acc_ab = accepts;
        check("t5_inflight_at_abort", bench_out > 0, 1);
        @(negedge clk);
        abort = 1'b0;
        exp_beats.delete(); exp_addr.delete();
        wait_done(n0);
        check("t5_no_new_reqs", accepts, acc_ab);
        check("t5_aborted", done_abt, 1);
        check("t5_drained", bench_out + pend.size(), 0);
        lat = 1;

        // Error on 4th beat of 6
        err_idx = 3;
        n0 = done_cnt;
        run_start(32'h100, 3, 2, 32'h40);
        wait_done(n0);
        err_idx = -1;
        check("t6_beats", pops, 6);
        check("t6_status", {done_abt, done_err}, 2'b01);

        // Status cleared on next start
        n0 = done_cnt;
        run_start(32'h100, 1, 1, 32'h40);
        wait_done(n0);
        check("t7_status", {done_abt, done_err}, 0);
        check("t7_beats", pops, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
